rv32_alu_sequencer: RTL and testbench

Multicycle controller that runs 32-bit RV32 integer ALU operations through the shared 16-bit `rv32_adder_unit` in two passes: low half, then high half. Carry is chained between passes. It sits between instruction decode and writeback in the execute stage. It owns operand latching, half selection, subtract/compare encoding and the result handshake.

---
 rtl/rv32_alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rv32_alu_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu_sequencer.sv
// Two-pass RV32 ALU sequencer driving a shared 16-bit adder slice (low half, then high half).
// Define ALU_SEQ_SLT_EN to implement SLT/SLTU; otherwise opcodes 101/110 complete as illegal.
module rv32_alu_sequencer (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_operand_a,
   input  logic [31:0] i_operand_b,
   output logic        o_valid,
   input  logic        i_result_ready,
   output logic [31:0] o_result,
   output logic        o_illegal,
   output logic [15:0] o_adder_op_one,
   output logic [15:0] o_adder_op_two,
   output logic        o_adder_c_in,
   output logic [1:0]  o_adder_sel,
   input  logic [15:0] i_adder_result,
   input  logic        i_adder_carry_out
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t             state;
   logic [2:0]         op_q;
   logic [31:0]        a_q;
   logic [31:0]        b_q;
   logic [15:0]        lo_q;
   logic               carry_q;
   logic signed [31:0] diff;
   logic [31:0]        next_result;
   logic               next_illegal;
`ifdef ALU_SEQ_SLT_EN
   logic               b_sign;
   logic               ovf;
`endif

   function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SEQ_SLT_EN
      return op != 3'b111;
`else
      return op <= 3'b100;
`endif
   endfunction

   // Ops whose B operand is latched inverted and whose LO pass starts with carry-in 1.
   function automatic logic op_inverts(input logic [2:0] op);
`ifdef ALU_SEQ_SLT_EN
      return (op == 3'b001) || (op == 3'b101) || (op == 3'b110);
`else
      return op == 3'b001;
`endif
   endfunction

   function automatic logic op_arith(input logic [2:0] op);
      return (op == 3'b000) || op_inverts(op);
   endfunction

   function automatic logic [1:0] op_sel(input logic [2:0] op);
      case (op)
         3'b010:  return 2'b01;
         3'b011:  return 2'b10;
         3'b100:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   assign next_illegal = ~op_legal(op_q);

   always_comb begin
      diff        = {i_adder_result, lo_q};
      next_result = '0;
`ifdef ALU_SEQ_SLT_EN
      b_sign = ~b_q[31];
      ovf    = (a_q[31] != b_sign) && (diff[31] != a_q[31]);
`endif
      case (op_q)
         3'b000, 3'b001, 3'b010, 3'b011, 3'b100: next_result = diff;
`ifdef ALU_SEQ_SLT_EN
         3'b101: next_result = {31'b0, diff[31] ^ ovf};
         3'b110: next_result = {31'b0, ~i_adder_carry_out};
`endif
         default: next_result = '0;
      endcase
   end

   always_comb begin
      o_adder_op_one = '0;
      o_adder_op_two = '0;
      o_adder_c_in   = 1'b0;
      o_adder_sel    = 2'b00;
      case (state)
         S_LO: begin
            o_adder_op_one = a_q[15:0];
            o_adder_op_two = b_q[15:0];
            o_adder_c_in   = op_inverts(op_q);
            o_adder_sel    = op_sel(op_q);
         end
         S_HI: begin
            o_adder_op_one = a_q[31:16];
            o_adder_op_two = b_q[31:16];
            o_adder_c_in   = op_arith(op_q) & carry_q;
            o_adder_sel    = op_sel(op_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         o_ready   <= 1'b1;
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_illegal <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  state   <= S_LO;
                  o_ready <= 1'b0;
               end
            end
            S_LO: begin
               carry_q <= i_adder_carry_out;
               state   <= S_HI;
            end
            S_HI: begin
               carry_q   <= i_adder_carry_out;
               o_result  <= next_result;
               o_illegal <= next_illegal;
               state     <= S_DONE;
            end
            S_DONE: begin
               // Result sits registered for a cycle before being offered.
               if (!o_valid) begin
                  o_valid <= 1'b1;
               end else if (i_result_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (state == S_IDLE && i_valid) begin
         op_q <= i_op;
         a_q  <= i_operand_a;
         b_q  <= op_inverts(i_op) ? ~i_operand_b : i_operand_b;
      end
      if (state == S_LO) begin
         lo_q <= i_adder_result;
      end
   end

endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// Scoreboard bench for rv32_alu_sequencer with a behavioural 16-bit adder slice attached.
module tb_rv32_alu_sequencer;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic [31:0] i_operand_a;
   logic [31:0] i_operand_b;
   logic        o_valid;
   logic        i_result_ready;
   logic [31:0] o_result;
   logic        o_illegal;
   logic [15:0] o_adder_op_one;
   logic [15:0] o_adder_op_two;
   logic        o_adder_c_in;
   logic [1:0]  o_adder_sel;
   logic [15:0] i_adder_result;
   logic        i_adder_carry_out;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   rv32_alu_sequencer dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_valid          (i_valid),
      .o_ready          (o_ready),
      .i_op             (i_op),
      .i_operand_a      (i_operand_a),
      .i_operand_b      (i_operand_b),
      .o_valid          (o_valid),
      .i_result_ready   (i_result_ready),
      .o_result         (o_result),
      .o_illegal        (o_illegal),
      .o_adder_op_one   (o_adder_op_one),
      .o_adder_op_two   (o_adder_op_two),
      .o_adder_c_in     (o_adder_c_in),
      .o_adder_sel      (o_adder_sel),
      .i_adder_result   (i_adder_result),
      .i_adder_carry_out(i_adder_carry_out)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic [16:0] add_sum;
   always_comb begin
      add_sum = {1'b0, o_adder_op_one} + {1'b0, o_adder_op_two} + {16'b0, o_adder_c_in};
      i_adder_carry_out = 1'b0;
      case (o_adder_sel)
         2'b00: begin
            i_adder_result    = add_sum[15:0];
            i_adder_carry_out = add_sum[16];
         end
         2'b01:   i_adder_result = o_adder_op_one | o_adder_op_two;
         2'b10:   i_adder_result = o_adder_op_one & o_adder_op_two;
         default: i_adder_result = o_adder_op_one ^ o_adder_op_two;
      endcase
   end

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.res = '0;
      e.ill = 1'b0;
      case (op)
         3'b000: e.res = a + b;
         3'b001: e.res = a - b;
         3'b010: e.res = a | b;
         3'b011: e.res = a & b;
         3'b100: e.res = a ^ b;
`ifdef ALU_SEQ_SLT_EN
         3'b101: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b110: e.res = (a < b) ? 32'd1 : 32'd0;
`endif
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic early_rdy, output logic lo_cin, output logic hi_cin);
      exp_t e;
      int   lat;
      @(negedge i_clk);
      total++;
      if (o_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_before_accept: got %b want 1", o_ready);
      end
      i_valid        = 1'b1;
      i_op           = op;
      i_operand_a    = a;
      i_operand_b    = b;
      i_result_ready = early_rdy;
      sb.push_back(model(op, a, b));
      @(negedge i_clk);
      i_valid     = 1'b0;
      i_op        = 3'($urandom_range(7, 0));
      i_operand_a = $urandom;
      i_operand_b = $urandom;
      lo_cin      = o_adder_c_in;
      @(negedge i_clk);
      hi_cin = o_adder_c_in;
      lat    = 2;
      while (o_valid !== 1'b1 && lat < 12) begin
         @(negedge i_clk);
         lat++;
      end
      e = sb.pop_front();
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL latency op=%0d: got %0d half-cycles-edges want 4", op, lat);
      end
      total++;
      if (o_result !== e.res) begin
         bad++;
         $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, o_result, e.res);
      end
      total++;
      if (o_illegal !== e.ill) begin
         bad++;
         $display("FAIL illegal op=%0d: got %b want %b", op, o_illegal, e.ill);
      end
      i_result_ready = 1'b1;
      @(negedge i_clk);
      total++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         bad++;
         $display("FAIL handshake_release: valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
      end
      i_result_ready = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n        = 1'b0;
      i_valid        = 1'b0;
      i_op           = 3'b000;
      i_operand_a    = '0;
      i_operand_b    = '0;
      i_result_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_handshake: ready=%b valid=%b want 1/0", o_ready, o_valid);
      end
      total++;
      if (o_result !== 32'h0 || o_illegal !== 1'b0) begin
         bad++;
         $display("FAIL reset_result: result=%h illegal=%b want 0/0", o_result, o_illegal);
      end
      total++;
      if ({o_adder_op_one, o_adder_op_two, o_adder_c_in, o_adder_sel} !== 35'h0) begin
         bad++;
         $display("FAIL reset_adder: one=%h two=%h cin=%b sel=%b want all 0",
                  o_adder_op_one, o_adder_op_two, o_adder_c_in, o_adder_sel);
      end
      i_rst_n = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic test_add_carry();
      logic lc, hc;
      run_op(3'b000, 32'h0000FFFF, 32'h00000001, 1'b0, lc, hc);
      total++;
      if (lc !== 1'b0 || hc !== 1'b1) begin
         bad++;
         $display("FAIL add_cin: lo=%b hi=%b want lo=0 hi=1", lc, hc);
      end
   endtask

   task automatic test_sub_logic();
      logic lc, hc;
      run_op(3'b001, 32'h00000000, 32'h00000001, 1'b0, lc, hc);
      total++;
      if (lc !== 1'b1 || hc !== 1'b0) begin
         bad++;
         $display("FAIL sub_cin: lo=%b hi=%b want lo=1 hi=0", lc, hc);
      end
      run_op(3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, lc, hc);
      total++;
      if (lc !== 1'b0 || hc !== 1'b0) begin
         bad++;
         $display("FAIL xor_cin: lo=%b hi=%b want 0/0", lc, hc);
      end
      run_op(3'b010, 32'h1234_0F0F, 32'h8000_F000, 1'b0, lc, hc);
      run_op(3'b011, 32'hFFFF_00FF, 32'h0F0F_FFFF, 1'b0, lc, hc);
   endtask

   task automatic test_compare();
      logic lc, hc;
      run_op(3'b101, 32'h80000000, 32'h00000001, 1'b0, lc, hc);
      run_op(3'b110, 32'h80000000, 32'h00000001, 1'b0, lc, hc);
      run_op(3'b101, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lc, hc);
      run_op(3'b110, 32'h00000001, 32'hFFFFFFFF, 1'b0, lc, hc);
   endtask

   task automatic test_reserved();
      logic lc, hc;
      run_op(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lc, hc);
   endtask

   task automatic test_back_to_back();
      logic lc, hc;
      for (int i = 0; i < 8; i++) begin
         run_op(3'($urandom_range(7, 0)), $urandom, $urandom, 1'b1, lc, hc);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   waitc;
      @(negedge i_clk);
      i_valid        = 1'b1;
      i_op           = 3'b000;
      i_operand_a    = 32'h12345678;
      i_operand_b    = 32'h11111111;
      i_result_ready = 1'b0;
      sb.push_back(model(3'b000, 32'h12345678, 32'h11111111));
      @(negedge i_clk);
      i_valid = 1'b0;
      waitc   = 0;
      while (o_valid !== 1'b1 && waitc < 10) begin
         @(negedge i_clk);
         waitc++;
      end
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         total++;
         if (o_valid !== 1'b1 || o_result !== e.res || o_ready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_hold[%0d]: valid=%b result=%h ready=%b want 1/%h/0",
                     k, o_valid, o_result, o_ready, e.res);
         end
         i_valid     = 1'b1;
         i_op        = 3'b001;
         i_operand_a = $urandom;
         i_operand_b = $urandom;
         @(negedge i_clk);
      end
      i_valid        = 1'b0;
      i_result_ready = 1'b1;
      @(negedge i_clk);
      total++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
      end
      i_result_ready = 1'b0;
      @(negedge i_clk);
      total++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== e.res) begin
         bad++;
         $display("FAIL backpressure_idle: valid=%b ready=%b result=%h want 0/1/%h",
                  o_valid, o_ready, o_result, e.res);
      end
   endtask

   task automatic test_reset_mid_op();
      logic lc, hc;
      logic seen;
      @(negedge i_clk);
      i_valid     = 1'b1;
      i_op        = 3'b000;
      i_operand_a = 32'hFFFF_FFFF;
      i_operand_b = 32'h0000_0003;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0 || o_illegal !== 1'b0) begin
         bad++;
         $display("FAIL midop_reset: ready=%b valid=%b result=%h illegal=%b want 1/0/0/0",
                  o_ready, o_valid, o_result, o_illegal);
      end
      total++;
      if ({o_adder_op_one, o_adder_op_two, o_adder_c_in, o_adder_sel} !== 35'h0) begin
         bad++;
         $display("FAIL midop_reset_adder: one=%h two=%h cin=%b sel=%b want all 0",
                  o_adder_op_one, o_adder_op_two, o_adder_c_in, o_adder_sel);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL midop_no_result: spurious valid=%b want 0", seen);
      end
      run_op(3'b000, 32'h0000FFFF, 32'h00010001, 1'b0, lc, hc);
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_sub_logic();
      test_compare();
      test_reserved();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_op();
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
